dp_sequencer: RTL and testbench



---
 rtl/dp_pkg.sv | 31 +++
 rtl/dp_decode.sv | 60 ++++++
 rtl/dp_sequencer.sv | 91 +++++++++
 tb/tb_dp_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared definitions for the ALU datapath sequencer.
//   - FSM state encoding (IDLE/EXEC/WB)
//   - instruction field slice positions
//   - special opcode/extension constants and the NOP word
//   - flag width
package dp_pkg;

    localparam int FLAG_W = 5;

    // Instruction field positions: op | rd | ext | rs, imm overlaps ext|rs.
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;

    localparam logic [3:0]  OP_RTYPE = 4'h0;
    localparam logic [3:0]  EXT_CMP  = 4'hB;
    localparam logic [3:0]  OP_CMPI  = 4'hB;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/dp_decode.sv
// dp_decode: combinational decode of a latched instruction word.
// Ports:
//   instr_i   - latched instruction word
//   opcode_o  - ALU opcode
//   rd_o      - destination/first-operand register
//   rs_o      - source register (0 for immediate form)
//   imm_sel_o - 0 selects the immediate, 1 selects the Rsrc register
//   imm_o     - extended immediate (0 for register form)
//   no_wb_o   - instruction writes no register (CMP, CMPI, NOP)
// Build option: IMM_SIGN_EXT_EN sign-extends the immediate; otherwise zero-extends.
module dp_decode
    import dp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [DATA_W-1:0] instr_i,
    output logic [7:0]        opcode_o,
    output logic [3:0]        rd_o,
    output logic [3:0]        rs_o,
    output logic              imm_sel_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              no_wb_o
);

    logic [3:0]       op, ext;
    logic [IMM_W-1:0] imm;
    logic [DATA_W-1:0] imm_ext;

    assign op   = instr_i[OP_HI:OP_LO];
    assign ext  = instr_i[EXT_HI:EXT_LO];
    assign imm  = instr_i[IMM_W-1:0];
    assign rd_o = instr_i[RD_HI:RD_LO];

`ifdef IMM_SIGN_EXT_EN
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
`else
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
`endif

    always_comb begin
        opcode_o  = 8'h00;
        rs_o      = 4'h0;
        imm_sel_o = 1'b0;
        imm_o     = '0;
        if (op == OP_RTYPE) begin
            opcode_o  = {4'h0, ext};
            rs_o      = instr_i[RS_HI:RS_LO];
            imm_sel_o = 1'b1;
        end else begin
            opcode_o  = {op, 4'h0};
            imm_o     = imm_ext;
        end
    end

    assign no_wb_o = ((op == OP_RTYPE) && (ext == EXT_CMP)) ||
                     (op == OP_CMPI) ||
                     (instr_i == NOP_WORD);

endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: three-state (IDLE/EXEC/WB) instruction sequencer for the
// 16-register ALU datapath. One instruction per 3 cycles.
// Ports:
//   clk, reset (async, active low)
//   instr/instr_valid/instr_ready - instruction handshake
//   alu_flags                     - ALU flags, captured in WB (not for NOP)
//   wEnable                       - one-hot register write enable, WB only
//   opcode, Rdest_select, Rsrc_select, Imm_select, Imm_in - datapath controls
//   flags_q                       - registered flags
//   done                          - one-cycle retire pulse (WB)
// Build option: IMM_SIGN_EXT_EN (see dp_decode).
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic [NUM_REGS-1:0] wEnable,
    output logic [7:0]          opcode,
    output logic [3:0]          Rdest_select,
    output logic [3:0]          Rsrc_select,
    output logic                Imm_select,
    output logic [DATA_W-1:0]   Imm_in,
    output logic [FLAG_W-1:0]   flags_q,
    output logic                done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] instr_q;

    logic [7:0]        dec_opcode;
    logic [3:0]        dec_rd, dec_rs;
    logic              dec_imm_sel, dec_no_wb;
    logic [DATA_W-1:0] dec_imm;
    logic              active;

    dp_decode #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_decode (
        .instr_i   (instr_q),
        .opcode_o  (dec_opcode),
        .rd_o      (dec_rd),
        .rs_o      (dec_rs),
        .imm_sel_o (dec_imm_sel),
        .imm_o     (dec_imm),
        .no_wb_o   (dec_no_wb)
    );

    assign instr_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_ready && instr_valid) instr_q <= instr;
            if (state_q == WB && instr_q != NOP_WORD) flags_q <= alu_flags;
        end
    end

    // Controls are only meaningful while an instruction is in flight; forcing
    // them to zero in IDLE gives clean reset values.
    assign active       = (state_q != IDLE);
    assign opcode       = active ? dec_opcode  : 8'h00;
    assign Rdest_select = active ? dec_rd      : 4'h0;
    assign Rsrc_select  = active ? dec_rs      : 4'h0;
    assign Imm_select   = active ? dec_imm_sel : 1'b0;
    assign Imm_in       = active ? dec_imm     : '0;

    // Derived from state, so an async reset in WB kills the write at once.
    assign wEnable = (state_q == WB && !dec_no_wb) ? (NUM_REGS'(1) << dec_rd) : '0;
    assign done    = (state_q == WB);

endmodule

// File: tb/tb_dp_sequencer.sv
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  alu_flags;
    logic [15:0] wEnable;
    logic [7:0]  opcode;
    logic [3:0]  Rdest_select, Rsrc_select;
    logic        Imm_select;
    logic [15:0] Imm_in;
    logic [4:0]  flags_q;
    logic        done;

    int total = 0;
    int bad   = 0;

    dp_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_flags    (alu_flags),
        .wEnable      (wEnable),
        .opcode       (opcode),
        .Rdest_select (Rdest_select),
        .Rsrc_select  (Rsrc_select),
        .Imm_select   (Imm_select),
        .Imm_in       (Imm_in),
        .flags_q      (flags_q),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    // Present one word for a single cycle, then scramble instr to prove it is ignored.
    task automatic issue(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
    endtask

`ifdef IMM_SIGN_EXT_EN
    localparam logic [15:0] IMM_FF = 16'hFFFF;
`else
    localparam logic [15:0] IMM_FF = 16'h00FF;
`endif

    initial begin
        reset       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        alu_flags   = 5'b00000;
        step();
        step();
        reset = 1'b1;
        samp();
        chk("rst_ready",  instr_ready, 1);
        chk("rst_wen",    wEnable, 0);
        chk("rst_done",   done, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_immsel", Imm_select, 0);
        chk("rst_immin",  Imm_in, 0);
        chk("rst_flags",  flags_q, 0);

        // ADD r1,r3
        alu_flags = 5'b00011;
        issue(16'h0153);
        samp();
        chk("add_exec_wen",   wEnable, 0);
        chk("add_exec_ready", instr_ready, 0);
        chk("add_exec_done",  done, 0);
        chk("add_exec_op",    opcode, 8'h05);
        step(); samp();
        chk("add_wb_wen",   wEnable, 16'h0002);
        chk("add_wb_op",    opcode, 8'h05);
        chk("add_wb_rd",    Rdest_select, 1);
        chk("add_wb_rs",    Rsrc_select, 3);
        chk("add_wb_isel",  Imm_select, 1);
        chk("add_wb_done",  done, 1);
        step(); samp();
        chk("add_idle_ready", instr_ready, 1);
        chk("add_idle_done",  done, 0);
        chk("add_idle_wen",   wEnable, 0);
        chk("add_flags",      flags_q, 5'b00011);

        // ADDI r2,0xFF
        alu_flags = 5'b01001;
        issue(16'h52FF);
        samp();
        chk("addi_exec_op",   opcode, 8'h50);
        chk("addi_exec_isel", Imm_select, 0);
        chk("addi_exec_rd",   Rdest_select, 2);
        chk("addi_exec_rs",   Rsrc_select, 0);
        chk("addi_exec_imm",  Imm_in, IMM_FF);
        step(); samp();
        chk("addi_wb_wen",  wEnable, 16'h0004);
        chk("addi_wb_imm",  Imm_in, IMM_FF);
        step(); samp();
        chk("addi_flags", flags_q, 5'b01001);

        // CMP r4,r7: no write, flags captured
        alu_flags = 5'b10100;
        issue(16'h04B7);
        samp();
        chk("cmp_exec_wen", wEnable, 0);
        chk("cmp_exec_op",  opcode, 8'h0B);
        step(); samp();
        chk("cmp_wb_wen",  wEnable, 0);
        chk("cmp_wb_done", done, 1);
        step(); samp();
        chk("cmp_idle_wen", wEnable, 0);
        chk("cmp_flags",    flags_q, 5'b10100);

        // CMPI r3,0x12: no write
        alu_flags = 5'b00110;
        issue(16'hB312);
        step(); samp();
        chk("cmpi_wb_wen",  wEnable, 0);
        chk("cmpi_wb_done", done, 1);
        step(); samp();
        chk("cmpi_flags", flags_q, 5'b00110);

        // NOP: no write, flags untouched
        alu_flags = 5'b11111;
        issue(16'h0000);
        samp();
        chk("nop_exec_done", done, 0);
        step(); samp();
        chk("nop_wb_wen",  wEnable, 0);
        chk("nop_wb_done", done, 1);
        step(); samp();
        chk("nop_flags", flags_q, 5'b00110);

        // Back-to-back: valid held high across two words
        alu_flags   = 5'b00001;
        instr       = 16'h0153;
        instr_valid = 1'b1;
        step();
        instr = 16'h0262;
        samp();
        chk("b2b_exec_ready", instr_ready, 0);
        chk("b2b_exec_op",    opcode, 8'h05);
        chk("b2b_exec_rd",    Rdest_select, 1);
        step(); samp();
        chk("b2b_wb_wen", wEnable, 16'h0002);
        chk("b2b_wb_op",  opcode, 8'h05);
        step(); samp();
        chk("b2b_idle_ready", instr_ready, 1);
        chk("b2b_idle_wen",   wEnable, 0);
        step();
        instr_valid = 1'b0;
        samp();
        chk("b2b2_exec_op", opcode, 8'h06);
        chk("b2b2_exec_rd", Rdest_select, 2);
        chk("b2b2_exec_rs", Rsrc_select, 2);
        step(); samp();
        chk("b2b2_wb_wen", wEnable, 16'h0004);
        step(); samp();
        chk("b2b2_idle_ready", instr_ready, 1);

        // Reset during WB of 0F10: write to r15 killed asynchronously
        alu_flags = 5'b10101;
        issue(16'h0F10);
        step(); samp();
        chk("rwb_wen_pre", wEnable, 16'h8000);
        #2 reset = 1'b0;
        #1;
        chk("rwb_wen",   wEnable, 0);
        chk("rwb_flags", flags_q, 0);
        chk("rwb_ready", instr_ready, 1);
        chk("rwb_done",  done, 0);
        step();
        reset = 1'b1;
        step(); samp();
        chk("rwb_post_flags", flags_q, 0);
        chk("rwb_post_wen",   wEnable, 0);
        chk("rwb_post_ready", instr_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
